// File: rtl/data_refill_ctrl_pkg.sv
// Shared cache geometry, address split positions and refill FSM encodings
// used by the data cache and its refill controller.
package data_refill_ctrl_pkg;

   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned WORD_W        = 32;
   localparam int unsigned CACHE_LINE_W  = 64;
   localparam int unsigned CACHE_INDEX_W = 3;
   localparam int unsigned CACHE_TAG_W   = 26;
   localparam int unsigned OFFSET_W      = 3;
   localparam int unsigned INDEX_LSB     = 3;
   localparam int unsigned TAG_LSB       = 6;
   localparam int unsigned LINE_ADDR_W   = ADDR_W - OFFSET_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ0  = 3'd1,
      ST_WAIT0 = 3'd2,
      ST_REQ1  = 3'd3,
      ST_WAIT1 = 3'd4,
      ST_FILL  = 3'd5
   } refill_state_e;

   // Byte address of word 0 or word 1 within a line
   function automatic logic [ADDR_W-1:0] word_addr(input logic [LINE_ADDR_W-1:0] line,
                                                   input logic                   word_sel);
      return {line, word_sel, 2'b00};
   endfunction

endpackage

// File: rtl/data_refill_ctrl.sv
// Data cache miss handler: fetches both words of the missing line from memory
// and writes the assembled line, tag and valid back in a single FILL cycle.
module data_refill_ctrl
   import data_refill_ctrl_pkg::*;
#(
   parameter int unsigned LINE_COUNT = 8,
   parameter int unsigned TAG_W      = CACHE_TAG_W,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            miss_req,
   input  logic [ADDR_W-1:0]               miss_addr,
   output logic                            fill_we,
   output logic [$clog2(LINE_COUNT)-1:0]   fill_index,
   output logic [TAG_W-1:0]                fill_tag,
   output logic [CACHE_LINE_W-1:0]         fill_data,
   output logic                            busy,
   output logic                            mem_req_valid,
   input  logic                            mem_req_ready,
   output logic [ADDR_W-1:0]               mem_req_addr,
   input  logic                            mem_resp_valid,
   input  logic [WORD_W-1:0]               mem_resp_data,
   output logic [CNT_W-1:0]                refill_count
);

   localparam int unsigned INDEX_W = $clog2(LINE_COUNT);

   refill_state_e            state_q, state_d;
   logic [ADDR_W-1:OFFSET_W] line_addr_q;
   logic [WORD_W-1:0]        word0_q;
   logic                     latch_miss;
   logic                     cap_word0;
   logic                     cap_word1;

   // Byte offset within the line never matters: both words are always fetched
   logic unused_offset;
   assign unused_offset = ^miss_addr[OFFSET_W-1:0];

   // Next-state and datapath strobes
   always_comb begin
      state_d    = state_q;
      latch_miss = 1'b0;
      cap_word0  = 1'b0;
      cap_word1  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (miss_req) begin
               latch_miss = 1'b1;
               state_d    = ST_REQ0;
            end
         end
         ST_REQ0: begin
            if (mem_req_ready) state_d = ST_WAIT0;
         end
         ST_WAIT0: begin
            if (mem_resp_valid) begin
               cap_word0 = 1'b1;
               state_d   = ST_REQ1;
            end
         end
         ST_REQ1: begin
            if (mem_req_ready) state_d = ST_WAIT1;
         end
         ST_WAIT1: begin
            if (mem_resp_valid) begin
               cap_word1 = 1'b1;
               state_d   = ST_FILL;
            end
         end
         ST_FILL: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register and registered outputs derived from the next state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         mem_req_valid <= 1'b0;
         fill_we       <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_req_valid <= (state_d == ST_REQ0) || (state_d == ST_REQ1);
         fill_we       <= (state_d == ST_FILL);
         busy          <= (state_d != ST_IDLE);
      end
   end

   // Address latch, word capture and line assembly
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         line_addr_q  <= '0;
         word0_q      <= '0;
         mem_req_addr <= '0;
         fill_index   <= '0;
         fill_tag     <= '0;
         fill_data    <= '0;
      end else begin
         if (latch_miss) begin
            line_addr_q  <= miss_addr[ADDR_W-1:OFFSET_W];
            mem_req_addr <= word_addr(miss_addr[ADDR_W-1:OFFSET_W], 1'b0);
         end
         if (cap_word0) begin
            word0_q      <= mem_resp_data;
            mem_req_addr <= word_addr(line_addr_q, 1'b1);
         end
         if (cap_word1) begin
            fill_data  <= {mem_resp_data, word0_q};
            fill_index <= line_addr_q[INDEX_LSB +: INDEX_W];
            fill_tag   <= line_addr_q[TAG_LSB +: TAG_W];
         end
      end
   end

   // Saturating count of completed refills
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         refill_count <= '0;
      end else if (state_q == ST_FILL && !(&refill_count)) begin
         refill_count <= refill_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_data_refill_ctrl.sv
// Directed bench for data_refill_ctrl: a cycle table for the basic and stalled
// refills plus hand sequences for reset abort, address change and saturation.
module tb_data_refill_ctrl;

   localparam int unsigned CNT_W = 3;

   logic        clock;
   logic        reset_n;
   logic        miss_req;
   logic [31:0] miss_addr;
   logic        fill_we;
   logic [2:0]  fill_index;
   logic [25:0] fill_tag;
   logic [63:0] fill_data;
   logic        busy;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic [CNT_W-1:0] refill_count;

   int checks = 0;
   int errors = 0;
   int hs_count = 0;

   data_refill_ctrl #(.LINE_COUNT(8), .TAG_W(26), .CNT_W(CNT_W)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .miss_req       (miss_req),
      .miss_addr      (miss_addr),
      .fill_we        (fill_we),
      .fill_index     (fill_index),
      .fill_tag       (fill_tag),
      .fill_data      (fill_data),
      .busy           (busy),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .refill_count   (refill_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock)
      if (reset_n && mem_req_valid && mem_req_ready) hs_count <= hs_count + 1;

   typedef struct {
      logic        miss;
      logic [31:0] addr;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        e_valid;
      logic [31:0] e_addr;
      logic        e_we;
      logic        e_busy;
      logic [2:0]  e_index;
      logic [25:0] e_tag;
      logic [63:0] e_data;
      int          e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic m, input logic [31:0] a, input logic rdy, input logic rv,
                      input logic [31:0] rd, input logic ev, input logic [31:0] ea,
                      input logic ew, input logic eb, input logic [2:0] ei,
                      input logic [25:0] et, input logic [63:0] ed, input int ec);
      vec_t v;
      v.miss = m; v.addr = a; v.rdy = rdy; v.rv = rv; v.rdata = rd;
      v.e_valid = ev; v.e_addr = ea; v.e_we = ew; v.e_busy = eb;
      v.e_index = ei; v.e_tag = et; v.e_data = ed; v.e_cnt = ec;
      vecs.push_back(v);
   endtask

   // Drives one complete refill with an always-ready memory answering one
   // cycle after each accepted request; returns at the negedge of the FILL cycle.
   task automatic run_miss(input logic [31:0] addr, input logic [31:0] alt_addr,
                           input logic [31:0] w0, input logic [31:0] w1, input logic hold,
                           output logic got_fill, output logic [2:0] idx,
                           output logic [25:0] tag, output logic [63:0] data);
      logic        pending = 1'b0;
      logic [31:0] paddr   = '0;
      got_fill = 1'b0; idx = '0; tag = '0; data = '0;
      miss_req = 1'b1;
      miss_addr = addr;
      mem_req_ready = 1'b1;
      for (int c = 0; c < 40 && !got_fill; c++) begin
         @(negedge clock);
         if (c == 1) miss_addr = alt_addr;
         mem_resp_valid = 1'b0;
         mem_resp_data  = 32'h0;
         if (fill_we) begin
            got_fill = 1'b1;
            idx = fill_index; tag = fill_tag; data = fill_data;
            miss_req = hold;
         end else begin
            if (pending) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = paddr[2] ? w1 : w0;
               pending = 1'b0;
            end
            if (mem_req_valid && mem_req_ready) begin
               pending = 1'b1;
               paddr   = mem_req_addr;
            end
         end
      end
      if (!got_fill) begin
         checks++;
         errors++;
         $display("FAIL refill_timeout actual=no_fill required=fill addr=%h", addr);
      end
   endtask

   logic        ok;
   logic [2:0]  r_idx;
   logic [25:0] r_tag;
   logic [63:0] r_data;

   initial begin
      reset_n = 1'b0; miss_req = 1'b0; miss_addr = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

      // Basic miss at 0x1044, then a second miss stalled by ready and hit by spurious responses
      add(1,32'h1044,1,0,32'h0,         0,32'h0,   0,0,3'd0,26'h0, 64'h0,0);
      add(1,32'h1044,1,0,32'h0,         1,32'h1040,0,1,3'd0,26'h0, 64'h0,0);
      add(1,32'h1044,1,1,32'hAAAA_0001, 0,32'h1040,0,1,3'd0,26'h0, 64'h0,0);
      add(1,32'h1044,1,0,32'h0,         1,32'h1044,0,1,3'd0,26'h0, 64'h0,0);
      add(1,32'h1044,1,1,32'hBBBB_0002, 0,32'h1044,0,1,3'd0,26'h0, 64'h0,0);
      add(1,32'h1044,1,0,32'h0,         0,32'h1044,1,1,3'd0,26'h41,64'hBBBB_0002_AAAA_0001,0);
      add(0,32'h1044,1,0,32'h0,         0,32'h1044,0,0,3'd0,26'h41,64'hBBBB_0002_AAAA_0001,1);
      add(1,32'h2008,0,1,32'hDEAD_0000, 0,32'h1044,0,0,3'd0,26'h41,64'hBBBB_0002_AAAA_0001,1);
      add(1,32'h2008,0,1,32'hDEAD_0001, 1,32'h2008,0,1,3'd0,26'h41,64'hBBBB_0002_AAAA_0001,1);
      add(1,32'h2008,0,0,32'h0,         1,32'h2008,0,1,3'd0,26'h41,64'hBBBB_0002_AAAA_0001,1);
      add(1,32'h2008,0,0,32'h0,         1,32'h2008,0,1,3'd0,26'h41,64'hBBBB_0002_AAAA_0001,1);
      add(1,32'h2008,1,0,32'h0,         1,32'h2008,0,1,3'd0,26'h41,64'hBBBB_0002_AAAA_0001,1);
      add(1,32'h2008,1,0,32'h0,         0,32'h2008,0,1,3'd0,26'h41,64'hBBBB_0002_AAAA_0001,1);
      add(1,32'h2008,1,1,32'h1111_0000, 0,32'h2008,0,1,3'd0,26'h41,64'hBBBB_0002_AAAA_0001,1);
      add(1,32'h2008,1,1,32'hEEEE_0000, 1,32'h200C,0,1,3'd0,26'h41,64'hBBBB_0002_AAAA_0001,1);
      add(1,32'h2008,1,1,32'h2222_0000, 0,32'h200C,0,1,3'd0,26'h41,64'hBBBB_0002_AAAA_0001,1);
      add(1,32'h2008,1,0,32'h0,         0,32'h200C,1,1,3'd1,26'h80,64'h2222_0000_1111_0000,1);
      add(0,32'h2008,1,0,32'h0,         0,32'h200C,0,0,3'd1,26'h80,64'h2222_0000_1111_0000,2);

      repeat (2) @(negedge clock);
      chk("reset_valid", 64'(mem_req_valid), 64'h0);
      chk("reset_busy",  64'(busy),          64'h0);
      chk("reset_we",    64'(fill_we),       64'h0);
      chk("reset_count", 64'(refill_count), 64'h0);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clock);
         miss_req = vecs[i].miss;   miss_addr = vecs[i].addr;
         mem_req_ready = vecs[i].rdy;
         mem_resp_valid = vecs[i].rv; mem_resp_data = vecs[i].rdata;
         chk($sformatf("row%0d_valid", i), 64'(mem_req_valid), 64'(vecs[i].e_valid));
         chk($sformatf("row%0d_addr", i),  64'(mem_req_addr),  64'(vecs[i].e_addr));
         chk($sformatf("row%0d_we", i),    64'(fill_we),       64'(vecs[i].e_we));
         chk($sformatf("row%0d_busy", i),  64'(busy),          64'(vecs[i].e_busy));
         chk($sformatf("row%0d_index", i), 64'(fill_index),    64'(vecs[i].e_index));
         chk($sformatf("row%0d_tag", i),   64'(fill_tag),      64'(vecs[i].e_tag));
         chk($sformatf("row%0d_data", i),  fill_data,          vecs[i].e_data);
         chk($sformatf("row%0d_count", i), 64'(refill_count),  64'(vecs[i].e_cnt));
      end
      chk("handshake_count", 64'(hs_count), 64'd4);
      mem_resp_valid = 1'b0;

      // miss_addr moves to 0x2000 mid-refill; held miss_req then refills 0x2000
      run_miss(32'h1044, 32'h2000, 32'h0101_0101, 32'h0202_0202, 1'b1, ok, r_idx, r_tag, r_data);
      chk("chg_first_index", 64'(r_idx), 64'd0);
      chk("chg_first_tag",   64'(r_tag), 64'h41);
      chk("chg_first_data",  r_data,     64'h0202_0202_0101_0101);
      run_miss(32'h2000, 32'h2000, 32'h0303_0303, 32'h0404_0404, 1'b0, ok, r_idx, r_tag, r_data);
      chk("chg_second_index", 64'(r_idx), 64'd0);
      chk("chg_second_tag",   64'(r_tag), 64'h80);
      chk("chg_second_data",  r_data,     64'h0404_0404_0303_0303);
      @(negedge clock);
      chk("chg_count", 64'(refill_count), 64'd4);
      chk("chg_idle",  64'(busy),         64'd0);

      // Reset pulsed during WAIT1 of a refill of 0x3050
      miss_req = 1'b1; miss_addr = 32'h3050; mem_req_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_0000;
      @(negedge clock);
      mem_resp_valid = 1'b0;
      @(negedge clock);
      chk("wait1_addr", 64'(mem_req_addr), 64'h3054);
      chk("wait1_busy", 64'(busy),         64'd1);
      miss_req = 1'b0;
      reset_n  = 1'b0;
      #1;
      chk("rst_valid", 64'(mem_req_valid), 64'd0);
      chk("rst_we",    64'(fill_we),       64'd0);
      chk("rst_busy",  64'(busy),          64'd0);
      chk("rst_count", 64'(refill_count),  64'd0);
      chk("rst_addr",  64'(mem_req_addr),  64'd0);
      chk("rst_index", 64'(fill_index),    64'd0);
      chk("rst_tag",   64'(fill_tag),      64'd0);
      chk("rst_data",  fill_data,          64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h8888_0000;
      @(negedge clock);
      mem_resp_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("late_we%0d", c),   64'(fill_we),       64'd0);
         chk($sformatf("late_busy%0d", c), 64'(busy),          64'd0);
         chk($sformatf("late_data%0d", c), fill_data,          64'd0);
         @(negedge clock);
      end
      run_miss(32'h3050, 32'h3050, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, ok, r_idx, r_tag, r_data);
      chk("post_rst_index", 64'(r_idx), 64'd2);
      chk("post_rst_tag",   64'(r_tag), 64'hC1);
      chk("post_rst_data",  r_data,     64'h9ABC_DEF0_1234_5678);
      @(negedge clock);
      chk("post_rst_count", 64'(refill_count), 64'd1);

      // Counter saturation: fills keep happening once the count is all-ones
      for (int k = 1; k <= 8; k++) begin
         run_miss(32'h0000_4000 + 32'(k * 8), 32'h0000_4000 + 32'(k * 8),
                  32'(k), 32'(k + 100), 1'b0, ok, r_idx, r_tag, r_data);
         chk($sformatf("sat_fill%0d", k), 64'(ok), 64'd1);
         chk($sformatf("sat_data%0d", k), r_data, {32'(k + 100), 32'(k)});
         @(negedge clock);
         chk($sformatf("sat_count%0d", k), 64'(refill_count),
             64'((1 + k) > 7 ? 7 : (1 + k)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_refill_ctrl.md
# data_refill_ctrl

Miss handler for the 8-line, 64-bit-line data cache. When the cache raises a read miss, it fetches the two 32-bit words of the missing line from data memory over a valid/ready request channel and an in-order response channel. It then writes the assembled 64-bit line, tag and valid bit back into the cache in one cycle. It sits between the cache's stall output and the data memory port; the pipeline stays stalled until the refill completes and the cache reports a hit.

## Interface
Parameters:
- `LINE_COUNT`, 8: cache lines, which sets the index width of 3.
- `TAG_W`, 26: tag width, address bits [31:6].
- `CNT_W`, 16: width of the refill statistics counter.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `miss_req`, in, 1: cache miss, driven from the cache's stall output (MemRead and not hit).
- `miss_addr`, in, 32: byte address of the missing load.
- `fill_we`, out, 1: one-cycle line write strobe to the cache.
- `fill_index`, out, 3: line index, from `miss_addr[5:3]`.
- `fill_tag`, out, 26: tag, from `miss_addr[31:6]`.
- `fill_data`, out, 64: assembled line, `{word1, word0}`.
- `busy`, out, 1: high whenever the state is not IDLE.
- `mem_req_valid`, out, 1: memory read request valid.
- `mem_req_ready`, in, 1: memory accepts the request.
- `mem_req_addr`, out, 32: word-aligned request address.
- `mem_resp_valid`, in, 1: read data valid; responses return in order.
- `mem_resp_data`, in, 32: read data.
- `refill_count`, out, CNT_W: number of completed refills; saturates at all-ones.

## Operation
- State machine: IDLE → REQ0 → WAIT0 → REQ1 → WAIT1 → FILL → IDLE.
- IDLE:
  - `miss_req` is sampled only in this state.
  - When `miss_req`=1, latch `miss_addr`, set `base = {miss_addr[31:3], 3'b000}`, and go to REQ0.
- REQ0 / REQ1:
  - `mem_req_valid`=1.
  - `mem_req_addr` is `base` in REQ0 and `base+4` in REQ1.
  - Address and valid stay stable while `mem_req_ready`=0.
  - On `valid && ready`, go to WAIT0 / WAIT1.
- WAIT0 / WAIT1:
  - On `mem_resp_valid`, capture word0 / word1 and go to REQ1 / FILL.
  - `mem_resp_valid` is ignored in every other state.
- FILL:
  - `fill_we`=1 for exactly one cycle, with index, tag and data driven from the latched registers.
  - `refill_count` increments (saturating), then go to IDLE.
- Outside FILL, `fill_we`=0. `fill_index`, `fill_tag` and `fill_data` hold their last values and are don't-care.
- Address bits [2:0] of `miss_addr` are ignored. Both words are always fetched, regardless of which word missed.
- Changes to `miss_req` or `miss_addr` during a refill are ignored. The refill always completes for the latched address.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - State returns to IDLE.
  - `mem_req_valid`=0, `fill_we`=0, `busy`=0, `refill_count`=0.
  - `mem_req_addr`, `fill_index`, `fill_tag`, `fill_data` and the word registers are all 0.
- Reset mid-refill aborts the refill with no `fill_we`. A response arriving after reset deasserts is dropped, because the controller is in IDLE.
- Minimum latency, with `mem_req_ready`=1 and the response one cycle after acceptance:
  - cycle 0: miss seen in IDLE
  - cycle 1: REQ0
  - cycle 2: WAIT0, response arrives
  - cycle 3: REQ1
  - cycle 4: WAIT1, response arrives
  - cycle 5: FILL, `fill_we`=1
  - cycle 6: IDLE; the cache now hits and `miss_req` drops.
- The cache updates its line at the same edge FILL→IDLE. `miss_req` therefore reflects the new line in the first IDLE cycle, and no spurious second refill occurs.
- A response is never accepted in the same cycle as its request handshake. The earliest accepted response is in the first WAIT cycle.
- `busy` is registered from state: 1 from the cycle after the miss is sampled through FILL inclusive.
- `refill_count` at all-ones stays at all-ones; FILL still completes normally.

## Structure
- Shared header `riscv_cache_defs.vh` holds:
  - `LINE_W`=64, `INDEX_W`=3, `TAG_W`=26
  - the offset-split bit positions
  - the state encodings (3-bit: IDLE=0, REQ0=1, WAIT0=2, REQ1=3, WAIT1=4, FILL=5).
- The cache module and this block both include this header.
- Single module, no sub-modules.
- Undefined state encodings (6, 7) go to IDLE.

## Test plan
- Miss at `miss_addr`=0x0000_1044, memory ready always, 1-cycle response, words 0xAAAA_0001 / 0xBBBB_0002:
  - requests go to 0x1040 then 0x1044
  - FILL at cycle 5 with index=0, tag=0x41, data=0xBBBB_0002_AAAA_0001
  - `refill_count`=1.
- `mem_req_ready` held low for 3 cycles in REQ0 → `mem_req_valid` and `mem_req_addr`=0x1040 stay stable for all 4 cycles; exactly one request is issued.
- Spurious `mem_resp_valid` in IDLE and in REQ0 → ignored. `fill_data` uses only the responses received in WAIT0 / WAIT1.
- `reset_n` pulsed low during WAIT1 → all outputs go to 0 immediately with no `fill_we`. A late response is ignored, and the next miss refills normally.
- `miss_addr` changes to 0x2000 mid-refill of 0x1044 → the fill targets tag 0x41, index 0. Holding `miss_req` after FILL starts a new refill for 0x2000 (index 0, tag 0x80).
- Preload `refill_count` to 0xFFFE, then run two misses → the count reads 0xFFFF and stays there.
